// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit: FSM states, ALU
// operation codes, instruction-class/cmd encodings and datapath select codes.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BRANCH
   } state_e;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_AND = 2'd2,
      ALU_ORR = 2'd3
   } alu_op_e;

   // Instruction class (op field)
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   // Data-processing cmd field (funct[4:1])
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   // ALU operand A select
   localparam logic [1:0] SRCA_REG = 2'b00;
   localparam logic [1:0] SRCA_PC  = 2'b01;

   // ALU operand B select
   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Result bus select
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/alu_cmd_decode.sv
// Combinational decode of the latched data-processing cmd field into an ALU
// operation plus the qualifiers the FSM needs (legal, compare-only, arithmetic).
module alu_cmd_decode
   import ctrl_pkg::*;
(
   input  logic [3:0] cmd,
   output alu_op_e    alu_op,
   output logic       valid,
   output logic       no_write,
   output logic       arith
);

   // Map cmd to ALU operation; unknown cmds are flagged invalid
   always_comb begin
      alu_op   = ALU_ADD;
      valid    = 1'b1;
      no_write = 1'b0;
      arith    = 1'b0;
      case (cmd)
         CMD_ADD: arith = 1'b1;
         CMD_SUB: begin
            alu_op = ALU_SUB;
            arith  = 1'b1;
         end
         CMD_AND: alu_op = ALU_AND;
         CMD_ORR: alu_op = ALU_ORR;
         CMD_CMP: begin
            alu_op   = ALU_SUB;
            arith    = 1'b1;
            no_write = 1'b1;
         end
         default: valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_decoder.sv
// Multicycle processor control FSM: sequences fetch, decode, memory, execute,
// writeback and branch states and drives the datapath strobes and selects.
module multicycle_decoder
   import ctrl_pkg::*;
#(
   parameter int REG_AW   = 4,
   parameter int ALUC_W   = 4,
   parameter int MEM_WAIT = 1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        op,
   input  logic [5:0]        funct,
   input  logic [REG_AW-1:0] rd,
   input  logic              cond_ex,
   input  logic              mem_ready,
   output logic              ir_write,
   output logic              pc_write,
   output logic              reg_w,
   output logic              mem_w,
   output logic              adr_src,
   output logic [1:0]        alu_src_a,
   output logic [1:0]        alu_src_b,
   output logic [1:0]        result_src,
   output logic [1:0]        imm_src,
   output logic [1:0]        reg_src,
   output logic [1:0]        flag_w,
   output logic [ALUC_W-1:0] alu_control,
   output logic              no_write,
   output logic              illegal
);

   state_e            state;
   state_e            state_nx;
   logic [1:0]        op_q;
   logic [3:0]        cmd_q;
   logic              sl_q;
   logic [REG_AW-1:0] rd_q;
   logic              mem_rdy;
   logic              pc_dest;
   alu_op_e           alu_sel;
   alu_op_e           dec_op;
   logic              dec_valid;
   logic              dec_nw;
   logic              dec_arith;

   assign mem_rdy     = (MEM_WAIT != 0) ? mem_ready : 1'b1;
   assign pc_dest     = &rd_q;
   assign alu_control = ALUC_W'(alu_sel);

   alu_cmd_decode u_cmd_dec (
      .cmd      (cmd_q),
      .alu_op   (dec_op),
      .valid    (dec_valid),
      .no_write (dec_nw),
      .arith    (dec_arith)
   );

   // State register; reset lands in FETCH immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= state_nx;
   end

   // Capture the instruction fields while in DECODE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q  <= '0;
         cmd_q <= '0;
         sl_q  <= 1'b0;
         rd_q  <= '0;
      end else if (state == S_DECODE) begin
         op_q  <= op;
         cmd_q <= funct[4:1];
         sl_q  <= funct[0];
         rd_q  <= rd;
      end
   end

   // Next-state and output decode; everything is forced quiet while in reset
   always_comb begin
      state_nx   = state;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_w      = 1'b0;
      mem_w      = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = SRCA_REG;
      alu_src_b  = SRCB_REG;
      result_src = RES_ALUOUT;
      imm_src    = 2'b00;
      reg_src    = 2'b00;
      flag_w     = 2'b00;
      alu_sel    = ALU_ADD;
      no_write   = 1'b0;
      illegal    = 1'b0;
      case (state)
         S_FETCH: begin
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
            if (mem_rdy) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_nx = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
            // Stores read Rd as a source; branches read the PC
            reg_src    = {op == OP_MEM, op == OP_BR};
            case (op)
               OP_MEM:  state_nx = S_MEMADR;
               OP_DP:   state_nx = funct[5] ? S_EXECI : S_EXECR;
               OP_BR:   state_nx = S_BRANCH;
               default: begin
                  illegal  = 1'b1;
                  state_nx = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_b = SRCB_IMM;
            imm_src   = op_q;
            state_nx  = sl_q ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            adr_src = 1'b1;
            if (mem_rdy) state_nx = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = RES_DATA;
            if (pc_dest) pc_write = cond_ex;
            else         reg_w    = cond_ex;
            state_nx = S_FETCH;
         end
         S_MEMWR: begin
            adr_src = 1'b1;
            if (mem_rdy) begin
               mem_w    = cond_ex;
               state_nx = S_FETCH;
            end
         end
         S_EXECR, S_EXECI: begin
            if (state == S_EXECI) begin
               alu_src_b = SRCB_IMM;
               imm_src   = op_q;
            end
            if (dec_valid) begin
               alu_sel  = dec_op;
               flag_w   = {sl_q, sl_q & dec_arith};
               no_write = dec_nw;
               state_nx = S_ALUWB;
            end else begin
               // Unknown cmd: abandon the instruction without any writes
               illegal  = 1'b1;
               state_nx = S_FETCH;
            end
         end
         S_ALUWB: begin
            result_src = RES_ALUOUT;
            no_write   = dec_nw;
            if (pc_dest) pc_write = cond_ex & ~dec_nw;
            else         reg_w    = cond_ex & ~dec_nw;
            state_nx = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_b  = SRCB_IMM;
            imm_src    = op_q;
            result_src = RES_ALU;
            pc_write   = cond_ex;
            state_nx   = S_FETCH;
         end
         default: state_nx = S_FETCH;
      endcase
      if (!rst_n) begin
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         reg_w      = 1'b0;
         mem_w      = 1'b0;
         adr_src    = 1'b0;
         alu_src_a  = 2'b00;
         alu_src_b  = 2'b00;
         result_src = 2'b00;
         imm_src    = 2'b00;
         reg_src    = 2'b00;
         flag_w     = 2'b00;
         alu_sel    = ALU_ADD;
         no_write   = 1'b0;
         illegal    = 1'b0;
      end
   end

endmodule

// File: doc/multicycle_decoder.md
MULTICYCLE_DECODER -- requirements
Module: multicycle_decoder

Interface
REQ-001 SHALL provide parameter REG_AW, default 4: register-index width of rd.
REQ-002 SHALL provide parameter ALUC_W, default 4: alu_control width (>=2, upper bits zero).
REQ-003 SHALL provide parameter MEM_WAIT, default 1: 1 = honour mem_ready, 0 = treat mem_ready as 1.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 op  in  2  instruction class (00 data-proc, 01 memory, 10 branch, 11 illegal).
REQ-008 funct  in  6  instruction funct field ([5] I, [4:1] cmd, [0] S or L).
REQ-009 rd  in  REG_AW  destination register index.
REQ-010 cond_ex  in  1  condition-check pass, valid in DECODE and execute states.
REQ-011 mem_ready  in  1  memory access completes this cycle.
REQ-012 ir_write, pc_write, reg_w, mem_w, adr_src  out  1 each  datapath strobes/selects.
REQ-013 alu_src_a, alu_src_b, result_src, imm_src, reg_src, flag_w  out  2 each  datapath selects/flag enables.
REQ-014 alu_control  out  ALUC_W  ALU operation (0 ADD, 1 SUB, 2 AND, 3 ORR).
REQ-015 no_write, illegal  out  1 each  compare-only flag; one-cycle illegal-opcode pulse.

Function
REQ-016 SHALL implement states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
REQ-017 FETCH: ir_write=1, alu_control=ADD, pc_write=1 only in the cycle mem_ready=1, then go to DECODE; otherwise hold.
REQ-018 DECODE: latch op, funct, rd; next state op=01 -> MEMADR, op=00 and funct[5] -> EXECI, op=00 -> EXECR, op=10 -> BRANCH, op=11 -> FETCH with illegal=1 for one cycle.
REQ-019 MEMADR: funct[0]=1 -> MEMRD, else MEMWR; MEMRD: hold until mem_ready, then MEMWB.
REQ-020 MEMWR: mem_w=cond_ex during the cycle mem_ready=1, then FETCH; mem_w SHALL be 0 in all stall cycles.
REQ-021 EXECR/EXECI -> ALUWB -> FETCH; MEMWB and BRANCH -> FETCH.
REQ-022 Latched cmd decode: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 SUB with no_write=1; other cmd -> illegal pulse, return to FETCH from EXECR/EXECI with no writes.
REQ-023 flag_w[1]=S, flag_w[0]=S and cmd in {ADD, SUB, CMP}, asserted only in EXECR/EXECI.
REQ-024 reg_w SHALL be cond_ex and not no_write in ALUWB, and cond_ex in MEMWB; 0 elsewhere.
REQ-025 When latched rd is all-ones (PC), pc_write SHALL be asserted instead of reg_w in ALUWB/MEMWB, with the same cond_ex gating.
REQ-026 BRANCH: pc_write=cond_ex, imm_src=10, alu_src_b=01.
REQ-027 With mem_ready held high, latency SHALL be: data-processing 4 cycles, LDR 5, STR 4, B 3.
REQ-028 Unasserted outputs SHALL be 0, except alu_control, which SHALL be ADD outside the execute states.

Reset
REQ-029 rst_n low SHALL force FETCH immediately, clear latched fields, and drive all strobes, illegal and flag_w to 0.
REQ-030 Reset asserted mid-instruction SHALL abandon it with no further reg_w, mem_w or pc_write; after release, the first active edge SHALL be in FETCH.

Structure
REQ-031 The state enum, ALU op codes and op/cmd constants SHALL be placed in a shared package ctrl_pkg.
REQ-032 The cmd-to-ALU mapping SHALL be a combinational sub-module alu_cmd_decode; the FSM SHALL be in multicycle_decoder.

Verification
REQ-033 ADD S (op=00, funct=001001, rd=3, cond_ex=1, mem_ready=1) -> FETCH, DECODE, EXECR, ALUWB; reg_w=1 in cycle 4; flag_w=11 in cycle 3.
REQ-034 LDR (op=01, funct=011001) with mem_ready low 2 cycles in MEMRD -> MEMRD held 3 cycles; reg_w single pulse in MEMWB.
REQ-035 CMP (cmd=1010, S=1) -> no_write=1, flag_w=11, reg_w=0 in ALUWB.
REQ-036 B with cond_ex=0 -> pc_write=0 in BRANCH; next state FETCH.
REQ-037 op=11 -> illegal=1 for one cycle; back in FETCH 3rd cycle; no writes.
REQ-038 rst_n low in MEMWR -> mem_w=0 immediately; state FETCH after release.
